// File: rtl/data_in_packer_pkg.sv
// Shared constants and helpers for the narrow-to-wide input packer.
package data_in_pkg;

  // Assembly modes: sequential auto-increments the lane, addressed uses in_sel_i.
  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  // Widest lane mask the helpers can produce; callers cast down to their LANES.
  localparam int MAX_LANES = 64;

  // Number of IN_W lanes that make up one OUT_W word.
  function automatic int lanes_f(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  // One-hot lane mask for a lane index; lanes beyond MAX_LANES-1 give an empty mask.
  function automatic logic [MAX_LANES-1:0] onehot_f(input int unsigned sel);
    return MAX_LANES'(1) << sel;
  endfunction

endpackage

// File: rtl/data_in_packer_if.sv
// Bus bundle between the narrow user-project port and the packer.
//
// Handshake rules, for both the input beat and the output word:
//   a transfer happens on a rising clock edge where valid && ready are both 1;
//   valid, once raised, holds its payload stable until the transfer happens;
//   in_ready_o depends only on registered state and out_ready_i, never on in_valid_i.
interface data_in_packer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
);
  import data_in_pkg::*;

  localparam int LANES = lanes_f(IN_W, OUT_W);
  localparam int SEL_W = $clog2(LANES);

  logic              mode_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [IN_W-1:0]   in_data_i;
  logic [SEL_W-1:0]  in_sel_i;
  logic              in_last_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [OUT_W-1:0]  out_data_o;
  logic [LANES-1:0]  out_be_o;
  logic              dup_lane_o;
  logic              busy_o;

  // Producer / consumer side: drives beats, flush, mode and downstream ready.
  modport master (
    output mode_i, in_valid_i, in_data_i, in_sel_i, in_last_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_be_o, dup_lane_o, busy_o
  );

  // Packer side.
  modport slave (
    input  mode_i, in_valid_i, in_data_i, in_sel_i, in_last_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_be_o, dup_lane_o, busy_o
  );

endinterface

// File: rtl/data_in_packer_lane_merge.sv
// Combinational merge of one incoming beat into the partially assembled word.
// Produces the merged data/enables and flags a lane that was already written.
module lane_merge
  import data_in_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int LANES = 4,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic [IN_W*LANES-1:0] asm_data_i,
  input  logic [LANES-1:0]      asm_be_i,
  input  logic [IN_W-1:0]       in_data_i,
  input  logic [SEL_W-1:0]      lane_i,
  input  logic                  wr_en_i,
  output logic [IN_W*LANES-1:0] merged_data_o,
  output logic [LANES-1:0]      merged_be_o,
  output logic                  dup_o
);

  logic [LANES-1:0] lane_oh;

  // Overlay the beat onto its lane; all other lanes pass through untouched.
  always_comb begin
    lane_oh       = wr_en_i ? LANES'(onehot_f(32'(lane_i))) : '0;
    merged_data_o = asm_data_i;
    for (int k = 0; k < LANES; k++) begin
      if (lane_oh[k]) begin
        merged_data_o[k*IN_W +: IN_W] = in_data_i;
      end
    end
    merged_be_o = asm_be_i | lane_oh;
    dup_o       = |(asm_be_i & lane_oh);
  end

endmodule

// File: rtl/data_in_packer.sv
// Packs IN_W beats into OUT_W words, by auto-incrementing lane or by explicit
// lane select, and presents finished words through a one-entry valid/ready
// output register. Flush emits a partial word; unwritten lanes read as zero.
module data_in_packer
  import data_in_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n_i,
  data_in_packer_if.slave bus
);

  localparam int LANES = lanes_f(IN_W, OUT_W);
  localparam int SEL_W = $clog2(LANES);
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

  // Assembly state
  logic [OUT_W-1:0] asm_data_q, asm_data_d;
  logic [LANES-1:0] asm_be_q, asm_be_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             mode_q, mode_d;
  logic             flush_pend_q, flush_pend_d;
  logic             dup_q, dup_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0] out_be_q, out_be_d;

  // Held low through reset so in_ready_o only rises on the first clock after release.
  logic             ready_en_q, ready_en_d;

  // Combinational datapath
  logic             mode_eff;
  logic [SEL_W-1:0] lane;
  logic             in_ready;
  logic             accept;
  logic [OUT_W-1:0] merged_data;
  logic [LANES-1:0] merged_be;
  logic             lane_dup;
  logic             seq_full;
  logic             addr_full;
  logic             close_beat;
  logic             close_flush;
  logic             close;

  // Mode follows mode_i while nothing is assembled, so the first beat of a word
  // already uses the newly selected mode; it is frozen once a lane is written.
  always_comb begin
    mode_eff = (asm_be_q == '0) ? bus.mode_i : mode_q;
    lane     = (mode_eff == MODE_ADDR) ? bus.in_sel_i : ptr_q;
    in_ready = ready_en_q && (!out_valid_q || bus.out_ready_i);
    accept   = bus.in_valid_i && in_ready;
  end

  lane_merge #(
    .IN_W  (IN_W),
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_lane_merge (
    .asm_data_i    (asm_data_q),
    .asm_be_i      (asm_be_q),
    .in_data_i     (bus.in_data_i),
    .lane_i        (lane),
    .wr_en_i       (accept),
    .merged_data_o (merged_data),
    .merged_be_o   (merged_be),
    .dup_o         (lane_dup)
  );

  // Decide whether the word closes this cycle: on a beat (full, last, flush) or
  // from a pending flush once the output slot frees up.
  always_comb begin
    seq_full    = (mode_eff == MODE_SEQ) && (ptr_q == LAST_LANE);
    addr_full   = (mode_eff == MODE_ADDR) && (&merged_be);
    close_beat  = accept && (seq_full || addr_full || bus.in_last_i ||
                             bus.flush_i || flush_pend_q);
    close_flush = !accept && flush_pend_q && in_ready;
    close       = close_beat || close_flush;
  end

  // Next-state for assembly, flags and the output register.
  always_comb begin
    asm_data_d   = asm_data_q;
    asm_be_d     = asm_be_q;
    ptr_d        = ptr_q;
    mode_d       = mode_eff;
    flush_pend_d = flush_pend_q;
    dup_d        = (dup_q && !bus.flush_i) ||
                   (accept && (mode_eff == MODE_ADDR) && lane_dup);
    out_valid_d  = out_valid_q && !bus.out_ready_i;
    out_data_d   = out_data_q;
    out_be_d     = out_be_q;
    ready_en_d   = 1'b1;

    if (close) begin
      asm_data_d   = '0;
      asm_be_d     = '0;
      ptr_d        = '0;
      flush_pend_d = 1'b0;
      out_valid_d  = 1'b1;
      out_data_d   = merged_data;
      out_be_d     = merged_be;
    end else begin
      if (accept) begin
        asm_data_d = merged_data;
        asm_be_d   = merged_be;
        if (mode_eff == MODE_SEQ) begin
          ptr_d = (ptr_q == LAST_LANE) ? '0 : ptr_q + SEL_W'(1);
        end
      end
      if (bus.flush_i && (asm_be_q != '0)) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any partial or held word.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      asm_data_q   <= '0;
      asm_be_q     <= '0;
      ptr_q        <= '0;
      mode_q       <= MODE_SEQ;
      flush_pend_q <= 1'b0;
      dup_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_be_q     <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      asm_data_q   <= asm_data_d;
      asm_be_q     <= asm_be_d;
      ptr_q        <= ptr_d;
      mode_q       <= mode_d;
      flush_pend_q <= flush_pend_d;
      dup_q        <= dup_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_be_q     <= out_be_d;
      ready_en_q   <= ready_en_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_be_o    = out_be_q;
  assign bus.dup_lane_o  = dup_q;
  assign bus.busy_o      = (asm_be_q != '0) || out_valid_q;

endmodule
